pseudo_spi_rx_intf: RTL and testbench
=====================================

# pseudo_spi_rx_intf

Serial-to-SRAM loader: the receive end of the team's pseudo-SPI link. It deserializes bytes arriving on SPI_SI, qualified by the two-phase serial clocks SCLK1/SCLK2 and the byte strobe LAT, and writes them into the 512x8 SRAM. Bytes are written at descending addresses starting from ADDR_BGN. It mirrors the existing SRAM-to-serial transmitter and shares its SRAM port signalling. Typical use is loading instruction/data memory from an external tester before CPU start.

## Interface
- MEMORY_DATA_WIDTH, 8, SRAM word and serial byte width
- MEMORY_ADDR_WIDTH, 9, SRAM address width
- RESERVED_DATA_LEN, 8, width of DATA_LEN
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- BGN  input  1  enable; high = run/hold session, low = abort to idle
- ADDR_BGN  input  9  first (highest) write address, sampled on leaving IDLE
- DATA_LEN  input  8  byte count minus one, sampled on leaving IDLE
- SCLK1  input  1  serial phase-1 clock (asynchronous to CLK)
- SCLK2  input  1  serial phase-2 clock; data sampled on its rising edge
- LAT  input  1  byte-commit strobe (asynchronous to CLK)
- SPI_SI  input  1  serial data, LSB first
- CEN  output  1  SRAM chip enable, active low
- WEN  output  1  SRAM write enable, active low
- A  output  9  SRAM address
- D  output  8  SRAM write data
- FRM_ERR  output  1  sticky framing error, cleared on leaving IDLE
- spi_is_done  output  1  all DATA_LEN+1 bytes written

## Operation
- SCLK1, SCLK2, LAT and SPI_SI each pass through a 2-flop synchronizer. Rising edges are detected on the synchronized SCLK2 and LAT.
- States: RX_IDLE, RX_ARM, RX_SHIFT, RX_WRITE, RX_NEXT, RX_DONE.
- RX_IDLE: outputs inactive. BGN=1 -> RX_ARM.
- RX_ARM, one cycle: A<=ADDR_BGN, byte_cnt<=DATA_LEN, bit_cnt<=0, FRM_ERR<=0 -> RX_SHIFT.
- RX_SHIFT, on SCLK2 rising edge:
  - shreg<={SPI_SI_sync, shreg[7:1]}; bit_cnt increments, saturating at 9.
  - If synchronized SCLK1 is also high (phase overlap), the edge is ignored and FRM_ERR<=1.
- RX_SHIFT, on LAT rising edge:
  - bit_cnt==8: D<=shreg -> RX_WRITE.
  - Otherwise: byte discarded, FRM_ERR<=1, bit_cnt<=0, remain in RX_SHIFT. Address and count are unchanged.
- RX_WRITE, one cycle: CEN=0, WEN=0, A and D stable -> RX_NEXT.
- RX_NEXT: bit_cnt<=0.
  - byte_cnt==0 -> RX_DONE.
  - Else A<=A-1 (modulo 512, so 0 wraps to 511), byte_cnt<=byte_cnt-1 -> RX_SHIFT.
- RX_DONE: spi_is_done=1. Further SCLK/LAT activity is ignored. Return to RX_IDLE when BGN=0.
- BGN=0 in any state other than RX_IDLE -> RX_IDLE next cycle.
  - A write in RX_WRITE in that cycle still completes.
  - A partially received byte is dropped.
- LAT edges arriving in RX_WRITE or RX_NEXT are ignored. The bit count for the next byte starts from 0.

## Timing
- Reset values: CEN=1, WEN=1, A=0, D=0, FRM_ERR=0, spi_is_done=0, state RX_IDLE, shreg=0, counters 0. Synchronizer flops reset to 0.
- Input-to-action latency:
  - SCLK2 rising at the pin -> shreg updated 3 CLK later.
  - LAT rising at the pin -> RX_WRITE (CEN/WEN low) 3 CLK later, lasting exactly 1 CLK.
  - A decrements the cycle after the write.
- Serial timing requirements:
  - SCLK1, SCLK2 and LAT high and low times are each ≥ 4 CLK.
  - SPI_SI is stable from 2 CLK before until 4 CLK after each SCLK2 rise.
  - LAT rises only while SCLK1 and SCLK2 are both low, at least 4 CLK after the last SCLK2 fall.
- spi_is_done rises 2 CLK after the final write cycle.
- Throughput: at most 1 byte per 8x(SCLK period) + LAT period.

## Test plan
- Nominal:
  - Stimulus: ADDR_BGN=13, DATA_LEN=13; send bytes AB,00,00,3C,00,05,3D,9E,C3,D7,58,7A,01,C2, LSB first.
  - Response: these bytes land at SRAM[13] down to SRAM[0]; 14 single-cycle CEN/WEN pulses; spi_is_done=1; FRM_ERR=0.
- Short byte:
  - Stimulus: 5 bits then LAT, followed by a full byte 0x5A.
  - Response: no write for the short byte; FRM_ERR=1; 0x5A written at ADDR_BGN.
- Wrap-around:
  - Stimulus: ADDR_BGN=1, DATA_LEN=2; send 11,22,33.
  - Response: SRAM[1]=11, SRAM[0]=22, SRAM[511]=33.
- Abort:
  - Stimulus: BGN deasserted after 4 bits of the 2nd byte.
  - Response: RX_IDLE next cycle; only the 1st byte written; CEN/WEN high. Re-asserting BGN restarts at ADDR_BGN with FRM_ERR cleared.
- Reset mid-write:
  - Stimulus: RST asserted in the RX_WRITE cycle.
  - Response: the next cycle shows all outputs at reset values.
- Phase overlap:
  - Stimulus: SCLK2 rises while SCLK1 is high.
  - Response: bit not shifted in; FRM_ERR=1.

Source files
------------

// File: rtl/pseudo_spi_rx_intf_if.sv
// pseudo_spi_rx_intf_if: serial inputs (BGN, ADDR_BGN, DATA_LEN, SCLK1, SCLK2, LAT, SPI_SI) and SRAM write port (CEN, WEN, A, D) plus status (FRM_ERR, spi_is_done); master drives serial, slave is the receiver
interface pseudo_spi_rx_intf_if #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
);
  logic                         BGN;
  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
  logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
  logic                         SCLK1;
  logic                         SCLK2;
  logic                         LAT;
  logic                         SPI_SI;
  logic                         CEN;
  logic                         WEN;
  logic [MEMORY_ADDR_WIDTH-1:0] A;
  logic [MEMORY_DATA_WIDTH-1:0] D;
  logic                         FRM_ERR;
  logic                         spi_is_done;
  modport master (
    output BGN, ADDR_BGN, DATA_LEN, SCLK1, SCLK2, LAT, SPI_SI,
    input  CEN, WEN, A, D, FRM_ERR, spi_is_done
  );
  modport slave (
    input  BGN, ADDR_BGN, DATA_LEN, SCLK1, SCLK2, LAT, SPI_SI,
    output CEN, WEN, A, D, FRM_ERR, spi_is_done
  );
endinterface

// File: rtl/pseudo_spi_rx_intf.sv
// pseudo_spi_rx_intf: deserializes LSB-first bytes (SCLK2-sampled, LAT-committed) and writes them to SRAM at descending addresses from ADDR_BGN; ports CLK, RST and bus (slave modport)
module pseudo_spi_rx_intf #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
) (
  input logic                 CLK,
  input logic                 RST,
  pseudo_spi_rx_intf_if.slave bus
);
  localparam int BW = $clog2(MEMORY_DATA_WIDTH + 2);
  localparam logic [BW-1:0] FULL = BW'(MEMORY_DATA_WIDTH);
  localparam logic [BW-1:0] OVER = BW'(MEMORY_DATA_WIDTH + 1);
  typedef enum logic [2:0] {RX_IDLE, RX_ARM, RX_SHIFT, RX_WRITE, RX_NEXT, RX_DONE} state_t;
  state_t state, next;
  logic [1:0] sclk1_q, sclk2_q, lat_q, si_q;
  logic sclk2_d, lat_d, sclk2_rise, lat_rise;
  logic [MEMORY_DATA_WIDTH-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic [RESERVED_DATA_LEN-1:0] byte_cnt;
  assign sclk2_rise = sclk2_q[1] & ~sclk2_d;
  assign lat_rise = lat_q[1] & ~lat_d;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk1_q <= '0;
      sclk2_q <= '0;
      lat_q <= '0;
      si_q <= '0;
      sclk2_d <= 1'b0;
      lat_d <= 1'b0;
    end else begin
      sclk1_q <= {sclk1_q[0], bus.SCLK1};
      sclk2_q <= {sclk2_q[0], bus.SCLK2};
      lat_q <= {lat_q[0], bus.LAT};
      si_q <= {si_q[0], bus.SPI_SI};
      sclk2_d <= sclk2_q[1];
      lat_d <= lat_q[1];
    end
  end
  always_ff @(posedge CLK) state <= RST ? RX_IDLE : next;
  always_comb begin
    next = state;
    bus.CEN = state != RX_WRITE;
    bus.WEN = state != RX_WRITE;
    bus.spi_is_done = state == RX_DONE;
    case (state)
      RX_IDLE:  next = bus.BGN ? RX_ARM : RX_IDLE;
      RX_ARM:   next = RX_SHIFT;
      RX_SHIFT: next = lat_rise && bit_cnt == FULL ? RX_WRITE : RX_SHIFT;
      RX_WRITE: next = RX_NEXT;
      RX_NEXT:  next = byte_cnt == '0 ? RX_DONE : RX_SHIFT;
      RX_DONE:  next = RX_DONE;
      default:  next = RX_IDLE;
    endcase
    if (!bus.BGN) next = RX_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.A <= '0;
      bus.D <= '0;
      bus.FRM_ERR <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        RX_ARM: begin
          bus.A <= bus.ADDR_BGN;
          byte_cnt <= bus.DATA_LEN;
          bit_cnt <= '0;
          bus.FRM_ERR <= 1'b0;
        end
        RX_SHIFT: begin
          if (lat_rise) begin
            if (bit_cnt == FULL) bus.D <= shreg;
            else begin
              bus.FRM_ERR <= 1'b1;
              bit_cnt <= '0;
            end
          end else if (sclk2_rise) begin
            if (sclk1_q[1]) bus.FRM_ERR <= 1'b1;
            else begin
              shreg <= {si_q[1], shreg[MEMORY_DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt == OVER ? OVER : bit_cnt + 1'b1;
            end
          end
        end
        RX_NEXT: begin
          bit_cnt <= '0;
          if (byte_cnt != '0) begin
            bus.A <= bus.A - MEMORY_ADDR_WIDTH'(1);
            byte_cnt <= byte_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// tb_pseudo_spi_rx_intf: directed and randomized sessions checked against a write log and an address/data model
module tb_pseudo_spi_rx_intf;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  int long_pulses = 0;
  logic prev_wr = 1'b0;
  logic [8:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] exp_q[$];
  pseudo_spi_rx_intf_if bus ();
  pseudo_spi_rx_intf dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (!bus.CEN && !bus.WEN) begin
      if (prev_wr) long_pulses++;
      wa.push_back(bus.A);
      wd.push_back(bus.D);
    end
    prev_wr = !bus.CEN && !bus.WEN;
  end
  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic send_bit(logic b, logic overlap);
    bus.SPI_SI = b;
    tick(2);
    bus.SCLK1 = 1'b1;
    tick(4);
    if (!overlap) bus.SCLK1 = 1'b0;
    tick(4);
    bus.SCLK2 = 1'b1;
    tick(4);
    bus.SCLK2 = 1'b0;
    bus.SCLK1 = 1'b0;
    tick(4);
  endtask
  task automatic send_bits(logic [7:0] b, int n);
    for (int i = 0; i < n; i++) send_bit(b[i], 1'b0);
  endtask
  task automatic lat_pulse();
    bus.LAT = 1'b1;
    tick(4);
    bus.LAT = 1'b0;
    tick(4);
  endtask
  task automatic start(logic [8:0] a, logic [7:0] len);
    bus.BGN = 1'b0;
    tick(2);
    wa.delete();
    wd.delete();
    long_pulses = 0;
    bus.ADDR_BGN = a;
    bus.DATA_LEN = len;
    bus.BGN = 1'b1;
    tick(3);
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.spi_is_done !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
  endtask
  task automatic check_session(string tag, logic [8:0] a0, logic frm);
    chk({tag, "_count"}, wa.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], (a0 - i) & 9'h1ff);
      chk({tag, "_data"}, wd[i], exp_q[i]);
    end
    chk({tag, "_done"}, bus.spi_is_done, 1);
    chk({tag, "_frm"}, bus.FRM_ERR, frm);
    chk({tag, "_pulse"}, long_pulses, 0);
  endtask
  task automatic run_session(string tag, logic [8:0] a, logic [7:0] len);
    start(a, len);
    foreach (exp_q[i]) begin
      send_bits(exp_q[i], 8);
      lat_pulse();
    end
    wait_done();
    check_session(tag, a, 1'b0);
  endtask
  initial begin
    logic [8:0] a;
    logic [7:0] b;
    int n;
    bus.BGN = 0;
    bus.ADDR_BGN = 0;
    bus.DATA_LEN = 0;
    bus.SCLK1 = 0;
    bus.SCLK2 = 0;
    bus.LAT = 0;
    bus.SPI_SI = 0;
    tick(3);
    RST = 1'b0;
    tick(1);
    chk("rst_cen", bus.CEN, 1);
    chk("rst_wen", bus.WEN, 1);
    chk("rst_a", bus.A, 0);
    chk("rst_d", bus.D, 0);
    chk("rst_frm", bus.FRM_ERR, 0);
    chk("rst_done", bus.spi_is_done, 0);
    exp_q = '{8'hAB, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h05, 8'h3D, 8'h9E, 8'hC3, 8'hD7, 8'h58, 8'h7A, 8'h01, 8'hC2};
    run_session("nominal", 9'd13, 8'd13);
    exp_q = '{8'h11, 8'h22, 8'h33};
    run_session("wrap", 9'd1, 8'd2);
    for (int k = 0; k < 3; k++) begin
      exp_q.delete();
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      run_session("random", 9'($urandom), 8'(n - 1));
    end
    a = 9'($urandom);
    start(a, 8'd0);
    send_bits(8'h15, 5);
    lat_pulse();
    chk("short_frm", bus.FRM_ERR, 1);
    chk("short_nowrite", wa.size(), 0);
    send_bits(8'h5A, 8);
    bus.LAT = 1'b1;
    tick(3);
    chk("short_cen", bus.CEN, 0);
    chk("short_wen", bus.WEN, 0);
    chk("short_a", bus.A, a);
    chk("short_d", bus.D, 8'h5A);
    tick(1);
    chk("short_cen_1cyc", bus.CEN, 1);
    chk("short_done_early", bus.spi_is_done, 0);
    tick(1);
    chk("short_done_2clk", bus.spi_is_done, 1);
    bus.LAT = 1'b0;
    tick(4);
    exp_q = '{8'h5A};
    check_session("short", a, 1'b1);
    a = 9'($urandom);
    b = 8'($urandom);
    start(a, 8'd5);
    send_bits(b, 8);
    lat_pulse();
    send_bits(8'h00, 3);
    lat_pulse();
    chk("abort_frm_set", bus.FRM_ERR, 1);
    send_bits(8'hFF, 4);
    bus.BGN = 1'b0;
    tick(1);
    chk("abort_cen", bus.CEN, 1);
    chk("abort_wen", bus.WEN, 1);
    chk("abort_done", bus.spi_is_done, 0);
    tick(2);
    chk("abort_writes", wa.size(), 1);
    chk("abort_addr0", wa[0], a);
    chk("abort_data0", wd[0], b);
    chk("abort_frm_sticky", bus.FRM_ERR, 1);
    a = 9'($urandom);
    bus.ADDR_BGN = a;
    bus.DATA_LEN = 8'd0;
    bus.BGN = 1'b1;
    tick(3);
    chk("abort_frm_clr", bus.FRM_ERR, 0);
    b = 8'($urandom);
    send_bits(b, 8);
    lat_pulse();
    wait_done();
    chk("restart_writes", wa.size(), 2);
    chk("restart_addr", wa[1], a);
    chk("restart_data", wd[1], b);
    chk("restart_done", bus.spi_is_done, 1);
    a = 9'($urandom);
    b = 8'($urandom);
    start(a, 8'd0);
    send_bits(b, 4);
    send_bit(1'b1, 1'b1);
    for (int i = 4; i < 8; i++) send_bit(b[i], 1'b0);
    lat_pulse();
    wait_done();
    exp_q = '{b};
    check_session("overlap", a, 1'b1);
    a = 9'($urandom);
    b = 8'($urandom) | 8'h01;
    start(a, 8'd0);
    send_bits(b, 8);
    bus.LAT = 1'b1;
    n = 0;
    while (bus.CEN !== 1'b0 && n < 10) begin
      tick(1);
      n++;
    end
    chk("lat_latency", n, 3);
    chk("mw_d", bus.D, b);
    RST = 1'b1;
    bus.LAT = 1'b0;
    bus.BGN = 1'b0;
    tick(1);
    chk("mw_cen", bus.CEN, 1);
    chk("mw_wen", bus.WEN, 1);
    chk("mw_a", bus.A, 0);
    chk("mw_d0", bus.D, 0);
    chk("mw_frm", bus.FRM_ERR, 0);
    chk("mw_done", bus.spi_is_done, 0);
    RST = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
